bram_stream_reader: RTL and testbench

//  Read-side master for the SRAM-based capture buffer (bram_block_sram rd port). On a start

---
 rtl/bram_stream_reader.sv | 191 +++++++++++++++++++
 tb/tb_bram_stream_reader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Read-side master for the SRAM capture buffer. A start command walks
//   `length` words from `base_addr` (wrapping modulo DEPTH), absorbs the
//   RAM's fixed read latency and presents the words on a valid/ready stream
//   with an end-of-block marker.
//
//   state | meaning
//   IDLE  | waiting for start
//   READ  | issuing reads, throttled by FIFO credit
//   DRAIN | all reads issued, emptying latency pipe and FIFO
//
// Ports
//   clk, resetn          single clock, async active-low reset
//   start/base_addr/length  transfer command (sampled while busy=0)
//   abort                cancel transfer, flush everything, no done
//   busy, done           status / one-cycle completion pulse
//   rd_addr, re, rd_data RAM read port (data valid RD_LAT cycles after re)
//   m_data/m_valid/m_ready/m_last  output stream
module bram_stream_reader #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2048,
    parameter int RD_LAT = 1,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] rd_addr,
    output logic              re,
    input  logic [WIDTH-1:0]  rd_data,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0]     PTR_MAX  = PW'(FIFO_DEPTH - 1);
    localparam logic [AWIDTH-1:0] ADDR_MAX = AWIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [AWIDTH:0]   len_q, len_d;
    logic [AWIDTH:0]   issued_q, issued_d;
    logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;
    logic [RD_LAT-1:0] pipe_l_q, pipe_l_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [WIDTH-1:0]  fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
    logic              done_q, done_d;

    logic issue, issue_last, push, pop, final_hs, credit_ok;

    // Reads in flight plus words already buffered must leave room for one
    // more, so the FIFO can never overflow whatever m_ready does.
    assign credit_ok  = ({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < (CW+1)'(FIFO_DEPTH);
    assign issue      = (state_q == READ) && (issued_q != len_q) && credit_ok && !abort;
    assign issue_last = (issued_q + 1'b1) == len_q;
    assign push       = pipe_v_q[RD_LAT-1];
    assign pop        = m_valid && m_ready;
    assign final_hs   = pop && m_last;

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign rd_addr = addr_q;
    assign re      = issue;
    assign m_valid = (fifo_cnt_q != '0);
    assign m_data  = fifo_data_q[rd_ptr_q];
    assign m_last  = fifo_last_q[rd_ptr_q] && m_valid;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        issued_d    = issued_q;
        done_d      = 1'b0;
        pipe_v_d    = pipe_v_q;
        pipe_l_d    = pipe_l_q;
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = READ;
                        addr_d   = base_addr;
                        len_d    = length;
                        issued_d = '0;
                    end
                end
            end
            READ: begin
                if (issue && issue_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (final_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            addr_d   = (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
            issued_d = issued_q + 1'b1;
        end

        // Tag pipe mirrors the RAM latency; its exit marks valid rd_data.
        pipe_v_d[0] = issue;
        pipe_l_d[0] = issue && issue_last;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_l_d[i] = pipe_l_q[i-1];
        end

        outst_d = outst_q + CW'(issue) - CW'(push);

        if (push) begin
            fifo_data_d[wr_ptr_q] = rd_data;
            fifo_last_d[wr_ptr_q] = pipe_l_q[RD_LAT-1];
            wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
        end
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

        // Abort overrides everything, including a coincident start or final
        // handshake; clearing the tag pipe discards late RAM returns.
        if (abort) begin
            state_d    = IDLE;
            done_d     = 1'b0;
            pipe_v_d   = '0;
            pipe_l_d   = '0;
            outst_d    = '0;
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            pipe_v_q    <= '0;
            pipe_l_q    <= '0;
            outst_q     <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_last_q <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            pipe_v_q    <= pipe_v_d;
            pipe_l_q    <= pipe_l_d;
            outst_q     <= outst_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_last_q <= fifo_last_d;
            done_q      <= done_d;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= fifo_data_d[i];
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: one instance with RD_LAT=1, one with RD_LAT=2,
// each with its own behavioural RAM; `sel` picks which one a transfer uses.
module tb_bram_stream_reader;
    localparam int AW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn, start, abort, m_ready, sel;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          start1, start2;
    logic          busy1, done1, re1, mv1, ml1, busy2, done2, re2, mv2, ml2;
    logic [AW-1:0] ra1, ra2;
    logic [7:0]    rd1 = 8'h00, rd2 = 8'h00, stage2 = 8'h00, md1, md2;
    logic          busy_s, done_s, re_s, mv_s, ml_s;
    logic [AW-1:0] ra_s;
    logic [7:0]    md_s;

    assign start1 = start & ~sel;
    assign start2 = start & sel;
    assign busy_s = sel ? busy2 : busy1;
    assign done_s = sel ? done2 : done1;
    assign re_s   = sel ? re2   : re1;
    assign mv_s   = sel ? mv2   : mv1;
    assign ml_s   = sel ? ml2   : ml1;
    assign ra_s   = sel ? ra2   : ra1;
    assign md_s   = sel ? md2   : md1;

    bram_stream_reader #(.WIDTH(8), .DEPTH(2048), .RD_LAT(1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .base_addr(base), .length(len),
        .abort(abort), .busy(busy1), .done(done1), .rd_addr(ra1), .re(re1),
        .rd_data(rd1), .m_data(md1), .m_valid(mv1), .m_ready(m_ready), .m_last(ml1));

    bram_stream_reader #(.WIDTH(8), .DEPTH(2048), .RD_LAT(2)) dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .base_addr(base), .length(len),
        .abort(abort), .busy(busy2), .done(done2), .rd_addr(ra2), .re(re2),
        .rd_data(rd2), .m_data(md2), .m_valid(mv2), .m_ready(m_ready), .m_last(ml2));

    function automatic logic [7:0] data_of(input int a);
        return 8'((a * 13) ^ (a >> 4));
    endfunction

    always @(posedge clk) if (re1) rd1 <= data_of(int'(ra1));
    always @(posedge clk) begin
        if (re2) stage2 <= data_of(int'(ra2));
        rd2 <= stage2;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One transfer on the selected DUT. rnd: random m_ready. abort_at: stall
    // after that many words and abort. poke: issue a stray start while busy.
    task automatic xfer(input int b, input int n, input int rnd, input int abort_at, input int poke);
        int lat = sel ? 2 : 1;
        int fd = lat + 2;
        int cyc = 0, k = 0, issued = 0, last_cyc = -1, first_cyc = -1, prev_hs = -1;
        int stall = 0, extra = 0;
        logic prev_stall = 1'b0;
        logic [7:0] prev_d = 8'h00;
        logic prev_l = 1'b0;
        bit fin = 1'b0;
        @(negedge clk);
        start = 1'b1; base = AW'(b); len = (AW+1)'(n); m_ready = 1'b1;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke != 0 && cyc == 3) begin
                start = 1'b1; base = 11'h123; len = 12'd7;
            end
            if (abort) begin
                abort = 1'b0;
                chk("abort_busy", busy_s, 0);
                chk("abort_valid", mv_s, 0);
                chk("abort_re", re_s, 0);
                extra = 0;
                repeat (6) begin
                    @(negedge clk);
                    if (done_s) extra++;
                end
                chk("abort_no_done", extra, 0);
                fin = 1'b1;
            end else if (cyc > 8 * n + 60) begin
                chk("done_seen", done_s, 1);
                fin = 1'b1;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", mv_s, 1);
                    chk("stall_data", md_s, prev_d);
                    chk("stall_last", ml_s, prev_l);
                end
                if (re_s) begin
                    chk("rd_addr", ra_s, (b + issued) % 2048);
                    issued++;
                    chk("credit", (issued - k <= fd) && (issued <= n), 1);
                    if (issued == 1) chk("first_re_cyc", cyc, 1);
                end
                if (mv_s && first_cyc < 0) begin
                    first_cyc = cyc;
                    chk("first_valid_cyc", cyc, 2 + lat);
                end
                if (done_s) begin
                    chk("done_cyc", cyc, last_cyc + 1);
                    chk("done_busy", busy_s, 0);
                    chk("words", k, n);
                    chk("issued", issued, n);
                    extra = 0;
                    repeat (6) begin
                        @(negedge clk);
                        if (done_s) extra++;
                        if (re_s) extra++;
                    end
                    chk("done_once", extra, 0);
                    fin = 1'b1;
                end else begin
                    if (abort_at != 0 && k >= abort_at) begin
                        m_ready = 1'b0;
                        stall++;
                        if (stall == 3) abort = 1'b1;
                    end else begin
                        m_ready = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                    if (mv_s && m_ready) begin
                        chk("m_data", md_s, data_of((b + k) % 2048));
                        chk("m_last", ml_s, k == n - 1);
                        if (rnd == 0 && prev_hs >= 0) chk("back_to_back", cyc, prev_hs + 1);
                        prev_hs = cyc;
                        k++;
                        if (ml_s) last_cyc = cyc;
                    end
                    prev_stall = mv_s && !m_ready;
                    prev_d = md_s;
                    prev_l = ml_s;
                end
            end
        end
        m_ready = 1'b1;
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1; sel = 1'b0;
        base = '0; len = '0;
        #23;
        chk("rst1_outs", {busy1, done1, re1, mv1, ml1, ra1, md1}, 0);
        chk("rst2_outs", {busy2, done2, re2, mv2, ml2, ra2, md2}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy1, 0);

        // T1: wrap across the top of memory, with a stray start while busy
        xfer(11'h7FE, 4, 0, 0, 1);

        // T4: zero-length start
        @(negedge clk);
        start = 1'b1; base = 11'h005; len = '0;
        @(negedge clk);
        start = 1'b0;
        chk("zl_done", done1, 1);
        chk("zl_busy", busy1, 0);
        chk("zl_re", re1, 0);
        @(negedge clk);
        chk("zl_done_once", done1, 0);
        chk("zl_re2", re1, 0);

        // start coinciding with abort in IDLE: abort wins
        @(negedge clk);
        start = 1'b1; base = 11'h030; len = 12'd4; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy1, 0);
        chk("sa_re", re1, 0);
        @(negedge clk);
        chk("sa_busy2", busy1, 0);
        chk("sa_done", done1, 0);

        // T2: random back-pressure
        xfer(11'h0A0, 16, 1, 0, 0);

        // T5: abort after 5 of 10 words, then a clean short transfer
        xfer(11'h020, 10, 0, 5, 0);
        xfer(11'h010, 2, 0, 0, 0);

        // T3: RD_LAT=2, full-memory transfer
        sel = 1'b1;
        xfer(0, 2048, 0, 0, 0);
        sel = 1'b0;

        // T6: asynchronous reset in the middle of READ
        @(negedge clk);
        start = 1'b1; base = 11'h040; len = 12'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", busy1, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_outs", {busy1, done1, re1, mv1, ml1, ra1, md1}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy1, 0);
        xfer(11'h050, 3, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
